// File: rtl/glyph_plotter.sv
// glyph_plotter: latches one character cell request and streams its glyph as
// row-major pixel strobes with stall support. Reverse-video cursor: GLYPH_PLOTTER_CURSOR_EN.
module glyph_plotter #(
  parameter int unsigned          GLYPH_W     = 8,
  parameter int unsigned          GLYPH_H     = 16,
  parameter int unsigned          COL_W       = 5,
  parameter int unsigned          ROW_W       = 3,
  parameter int unsigned          X_W         = 8,
  parameter int unsigned          Y_W         = 7,
  parameter int unsigned          COLOUR_W    = 3,
  parameter logic [COLOUR_W-1:0]  FG          = 3'b111,
  parameter logic [COLOUR_W-1:0]  BG          = 3'b000,
  parameter int unsigned          TRANSPARENT = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6:0]          in_char,
  input  logic [COL_W-1:0]    in_col,
  input  logic [ROW_W-1:0]    in_row,
  input  logic                in_cursor,
  output logic                plot_valid,
  input  logic                plot_ready,
  output logic [X_W-1:0]      plot_x,
  output logic [Y_W-1:0]      plot_y,
  output logic [COLOUR_W-1:0] plot_colour,
  output logic                busy,
  output logic                done
);

  localparam int unsigned PXW = $clog2(GLYPH_W);
  localparam int unsigned PYW = $clog2(GLYPH_H);
`ifdef GLYPH_PLOTTER_CURSOR_EN
  localparam logic CURSOR_EN = 1'b1;
`else
  localparam logic CURSOR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_e;

  // Ten 8-bit rows, row 0 in the top byte; rows 9+ are blank except the 'Q' tail.
  function automatic logic [79:0] glyph_rows(input logic [6:0] code);
    logic [6:0]  c;
    logic [71:0] g;
    c = code;
    if (code >= 7'd97 && code <= 7'd122) c = code - 7'd32;
    case (c)
      7'd48: g = 72'h00_3C_66_6E_76_66_66_66_3C;
      7'd49: g = 72'h00_18_38_18_18_18_18_18_7C;
      7'd50: g = 72'h00_3C_66_06_0C_18_30_60_7E;
      7'd51: g = 72'h00_3C_66_06_1C_06_06_66_3C;
      7'd52: g = 72'h00_0C_1C_3C_6C_7E_0C_0C_0C;
      7'd53: g = 72'h00_7E_60_7C_06_06_06_66_3C;
      7'd54: g = 72'h00_3C_60_60_7C_66_66_66_3C;
      7'd55: g = 72'h00_7E_06_0C_18_30_30_30_30;
      7'd56: g = 72'h00_3C_66_66_3C_66_66_66_3C;
      7'd57: g = 72'h00_3C_66_66_3E_06_06_0C_38;
      7'd65: g = 72'h00_18_3C_66_66_7E_66_66_66;
      7'd66: g = 72'h00_7C_66_66_7C_66_66_66_7C;
      7'd67: g = 72'h00_3C_66_60_60_60_60_66_3C;
      7'd68: g = 72'h00_78_6C_66_66_66_66_6C_78;
      7'd69: g = 72'h00_7E_60_60_7C_60_60_60_7E;
      7'd70: g = 72'h00_7E_60_60_7C_60_60_60_60;
      7'd71: g = 72'h00_3C_66_60_6E_66_66_66_3C;
      7'd72: g = 72'h00_66_66_66_7E_66_66_66_66;
      7'd73: g = 72'h00_3C_18_18_18_18_18_18_3C;
      7'd74: g = 72'h00_1E_0C_0C_0C_0C_6C_6C_38;
      7'd75: g = 72'h00_66_6C_78_70_78_6C_66_66;
      7'd76: g = 72'h00_60_60_60_60_60_60_60_7E;
      7'd77: g = 72'h00_63_77_7F_6B_63_63_63_63;
      7'd78: g = 72'h00_66_76_7E_7E_6E_66_66_66;
      7'd79: g = 72'h00_3C_66_66_66_66_66_66_3C;
      7'd80: g = 72'h00_7C_66_66_7C_60_60_60_60;
      7'd81: g = 72'h00_3C_66_66_66_66_6A_6C_36;
      7'd82: g = 72'h00_7C_66_66_7C_78_6C_66_66;
      7'd83: g = 72'h00_3C_66_60_3C_06_06_66_3C;
      7'd84: g = 72'h00_7E_18_18_18_18_18_18_18;
      7'd85: g = 72'h00_66_66_66_66_66_66_66_3C;
      7'd86: g = 72'h00_66_66_66_66_66_66_3C_18;
      7'd87: g = 72'h00_63_63_63_63_6B_7F_77_63;
      7'd88: g = 72'h00_66_66_3C_18_3C_66_66_66;
      7'd89: g = 72'h00_66_66_66_3C_18_18_18_18;
      7'd90: g = 72'h00_7E_06_0C_18_30_60_60_7E;
      default: g = '0;
    endcase
    return {g, (c == 7'd81) ? 8'h02 : 8'h00};
  endfunction

  function automatic logic glyph_bit(input logic [79:0] rows, input logic [PXW-1:0] x,
                                     input logic [PYW-1:0] y);
    logic [7:0] r;
    if (32'(y) > 32'd9 || 32'(x) > 32'd7) return 1'b0;
    r = 8'(rows >> (32'd8 * (32'd9 - 32'(y))));
    return 1'(r >> (32'd7 - 32'(x)));
  endfunction

  state_e                state_q, state_d;
  logic [6:0]            char_q, char_d;
  logic [COL_W-1:0]      ccol_q, ccol_d;
  logic [ROW_W-1:0]      crow_q, crow_d;
  logic                  cursor_q, cursor_d;
  logic [79:0]           bank_q, bank_d;
  logic [PXW-1:0]        px_q, px_d;
  logic [PYW-1:0]        py_q, py_d;
  logic                  pv_q, pv_d;
  logic [X_W-1:0]        x_q, x_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic [COLOUR_W-1:0]   colour_q, colour_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  present, bitv;
  logic [79:0]           src;

  always_comb begin
    state_d  = state_q;
    char_d   = char_q;
    ccol_d   = ccol_q;
    crow_d   = crow_q;
    cursor_d = cursor_q;
    bank_d   = bank_q;
    px_d     = px_q;
    py_d     = py_q;
    pv_d     = pv_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    busy_d   = busy_q;
    done_d   = done_q;
    present  = 1'b0;
    src      = bank_q;
    bitv     = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        char_d   = in_char;
        ccol_d   = in_col;
        crow_d   = in_row;
        cursor_d = in_cursor;
        busy_d   = 1'b1;
        state_d  = LOAD;
      end
      LOAD: begin
        // Pixel 0 is registered straight from the decoder so it appears the cycle after LOAD.
        bank_d  = glyph_rows(char_q);
        src     = bank_d;
        px_d    = '0;
        py_d    = '0;
        present = 1'b1;
        state_d = DRAW;
      end
      DRAW: if (!pv_q || plot_ready) begin
        if (&px_q && &py_q) begin
          pv_d    = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          px_d    = px_q + PXW'(1);
          py_d    = (&px_q) ? py_q + PYW'(1) : py_q;
          present = 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (present) begin
      bitv     = glyph_bit(src, px_d, py_d) ^ (cursor_q & CURSOR_EN);
      colour_d = bitv ? FG : BG;
      pv_d     = (TRANSPARENT != 0) ? bitv : 1'b1;
      x_d      = X_W'({ccol_q, px_d});
      y_d      = Y_W'({crow_q, py_d});
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      char_q   <= '0;
      ccol_q   <= '0;
      crow_q   <= '0;
      cursor_q <= 1'b0;
      bank_q   <= '0;
      px_q     <= '0;
      py_q     <= '0;
      pv_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      char_q   <= char_d;
      ccol_q   <= ccol_d;
      crow_q   <= crow_d;
      cursor_q <= cursor_d;
      bank_q   <= bank_d;
      px_q     <= px_d;
      py_q     <= py_d;
      pv_q     <= pv_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign plot_valid  = pv_q;
  assign plot_x      = x_q;
  assign plot_y      = y_q;
  assign plot_colour = colour_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_glyph_plotter.sv
// Directed bench for glyph_plotter: opaque and transparent instances, stall, wrap,
// reset mid-draw and cursor behaviour (follows GLYPH_PLOTTER_CURSOR_EN).
module tb_glyph_plotter;

`ifdef GLYPH_PLOTTER_CURSOR_EN
  localparam bit CUR_EN = 1'b1;
`else
  localparam bit CUR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid, in_valid_t;
  logic [6:0] in_char;
  logic [4:0] in_col;
  logic [2:0] in_row;
  logic       in_cursor, plot_ready;

  logic       o_rdy, o_pv, o_busy, o_done, t_rdy, t_pv, t_busy, t_done;
  logic [7:0] o_x, t_x;
  logic [6:0] o_y, t_y;
  logic [2:0] o_c, t_c;

  always #5 clk = ~clk;

  glyph_plotter dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(o_rdy),
    .in_char(in_char), .in_col(in_col), .in_row(in_row), .in_cursor(in_cursor),
    .plot_valid(o_pv), .plot_ready(plot_ready), .plot_x(o_x), .plot_y(o_y),
    .plot_colour(o_c), .busy(o_busy), .done(o_done)
  );

  glyph_plotter #(.TRANSPARENT(1)) dut_t (
    .clk(clk), .resetn(resetn), .in_valid(in_valid_t), .in_ready(t_rdy),
    .in_char(in_char), .in_col(in_col), .in_row(in_row), .in_cursor(in_cursor),
    .plot_valid(t_pv), .plot_ready(plot_ready), .plot_x(t_x), .plot_y(t_y),
    .plot_colour(t_c), .busy(t_busy), .done(t_done)
  );

  bit         sel = 1'b0;
  logic       rdy, pv, bz, dn;
  logic [7:0] xx;
  logic [6:0] yy;
  logic [2:0] cc;
  assign rdy = sel ? t_rdy  : o_rdy;
  assign pv  = sel ? t_pv   : o_pv;
  assign bz  = sel ? t_busy : o_busy;
  assign dn  = sel ? t_done : o_done;
  assign xx  = sel ? t_x    : o_x;
  assign yy  = sel ? t_y    : o_y;
  assign cc  = sel ? t_c    : o_c;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int t0, strobes, done_n, hold_err, coord_err, bg_cnt, stalls, diff;
  int first_x, first_y, last_x, last_y;
  logic [7:0] img [16];
  logic [7:0] h_img [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [6:0] ch, input int col, input int row, input logic cur);
    @(negedge clk);
    in_char = ch; in_col = 5'(col); in_row = 3'(row); in_cursor = cur;
    if (sel) in_valid_t = 1'b1; else in_valid = 1'b1;
    for (int i = 0; i < 400 && !rdy; i++) @(negedge clk);
    @(posedge clk); #1;
    t0 = cyc;
    in_valid = 1'b0; in_valid_t = 1'b0;
  endtask

  // Samples #1 after each edge; n is the cycle number relative to acceptance (LOAD = 1).
  task automatic collect(input int col, input int row, input bit stall);
    int n, k;
    bit stalled_this, stalled_prev;
    logic [7:0] px_prev; logic [6:0] py_prev; logic [2:0] pc_prev;
    strobes = 0; done_n = -1; hold_err = 0; coord_err = 0; bg_cnt = 0; stalls = 0;
    stalled_this = 0; stalled_prev = 0; px_prev = '0; py_prev = '0; pc_prev = '0;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    for (int r = 0; r < 16; r++) img[r] = 8'h00;
    plot_ready = 1'b1;
    n = 1;
    while (n < 600) begin
      @(posedge clk); #1;
      n = cyc - t0 + 1;
      if (stalled_prev && (!pv || xx !== px_prev || yy !== py_prev || cc !== pc_prev))
        hold_err++;
      if (dn) begin done_n = n; break; end
      if (pv) begin
        k = n - 2 - stalls;
        if (stall && (k % 2 == 1) && !stalled_this) begin
          plot_ready = 1'b0; stalled_this = 1; stalled_prev = 1; stalls++;
          px_prev = xx; py_prev = yy; pc_prev = cc;
        end else begin
          plot_ready = 1'b1; stalled_this = 0; stalled_prev = 0;
          if (strobes == 0) begin first_x = int'(xx); first_y = int'(yy); end
          last_x = int'(xx); last_y = int'(yy);
          strobes++;
          if (cc == 3'b000) bg_cnt++;
          if (k >= 0 && k < 128) begin
            if (cc == 3'b111) img[4'(k / 8)] = img[4'(k / 8)] | (8'h80 >> (k % 8));
            if (int'(xx) != (col * 8 + k % 8) % 256) coord_err++;
            if (int'(yy) != (row * 16 + k / 8) % 128) coord_err++;
          end else coord_err++;
        end
      end else begin
        plot_ready = 1'b1; stalled_prev = 0;
      end
    end
    plot_ready = 1'b1;
  endtask

  int dn_cnt;
  logic [7:0] tail;

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_valid_t = 1'b0; in_char = '0;
    in_col = '0; in_row = '0; in_cursor = 1'b0; plot_ready = 1'b1;
    #1;
    check("reset_plot_valid", o_pv, 0);
    check("reset_plot_x", o_x, 0);
    check("reset_plot_y", o_y, 0);
    check("reset_colour", o_c, 0);
    check("reset_done", o_done, 0);
    check("reset_busy", o_busy, 0);
    check("reset_in_ready", o_rdy, 1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Digit '1' at col 2 row 1
    send(7'd49, 2, 1, 1'b0);
    check("one_busy_load", bz, 1);
    check("one_ready_load", rdy, 0);
    collect(2, 1, 0);
    check("one_strobes", strobes, 128);
    check("one_coords", coord_err, 0);
    check("one_row8", img[8], 8'h7C);
    tail = 8'h00;
    for (int r = 9; r < 16; r++) tail = tail | img[r];
    check("one_rows9_15", tail, 8'h00);
    check("one_done_cycle", done_n, 130);
    @(posedge clk); #1;
    check("one_ready_after", rdy, 1);
    check("one_done_pulse", dn, 0);
    check("one_busy_after", bz, 0);

    // 'H' with every odd pixel stalled once
    send(7'd72, 0, 0, 1'b0);
    collect(0, 0, 1);
    check("stall_count", stalls, 64);
    check("stall_hold", hold_err, 0);
    check("stall_strobes", strobes, 128);
    check("stall_row4", img[4], 8'h7E);
    check("stall_done_cycle", done_n, 194);
    for (int r = 0; r < 16; r++) h_img[r] = img[r];

    // Lowercase 'h' folds to 'H'
    send(7'd104, 0, 0, 1'b0);
    collect(0, 0, 0);
    diff = 0;
    for (int r = 0; r < 16; r++) if (img[r] !== h_img[r]) diff++;
    check("lower_same_as_upper", diff, 0);
    check("lower_row4", img[4], 8'h7E);
    check("lower_done_cycle", done_n, 130);

    // Undefined code and space are blank
    send(7'd35, 3, 2, 1'b0);
    collect(3, 2, 0);
    check("hash_strobes", strobes, 128);
    check("hash_bg", bg_cnt, 128);
    send(7'd32, 4, 3, 1'b0);
    collect(4, 3, 0);
    check("space_strobes", strobes, 128);
    check("space_bg", bg_cnt, 128);

    // Transparent instance: space gives no strobes, same timing
    sel = 1'b1;
    send(7'd32, 1, 1, 1'b0);
    collect(1, 1, 0);
    check("transp_space_strobes", strobes, 0);
    check("transp_space_done", done_n, 130);
    sel = 1'b0;

    // 'Q' tail row
    send(7'd81, 0, 0, 1'b0);
    collect(0, 0, 0);
    check("q_row9", img[9], 8'h02);
    check("q_row10", img[10], 8'h00);

    // Wrap at the last cell column/row
    send(7'd65, 31, 7, 1'b0);
    collect(31, 7, 0);
    check("wrap_coords", coord_err, 0);
    check("wrap_first_x", first_x, 248);
    check("wrap_first_y", first_y, 112);
    check("wrap_last_x", last_x, 255);
    check("wrap_last_y", last_y, 127);
    check("wrap_done", done_n, 130);

    // Cursor on '0'
    send(7'd48, 0, 0, 1'b1);
    collect(0, 0, 0);
    check("cursor_row0", img[0], CUR_EN ? 8'hFF : 8'h00);
    check("cursor_row10", img[10], CUR_EN ? 8'hFF : 8'h00);

    // Reset asserted at pixel 50
    send(7'd49, 2, 1, 1'b0);
    for (int i = 0; i < 200 && (cyc - t0 + 1) < 52; i++) begin @(posedge clk); #1; end
    check("mid_valid_before_reset", o_pv, 1);
    resetn = 1'b0;
    #1;
    check("mid_reset_valid", o_pv, 0);
    check("mid_reset_x", o_x, 0);
    check("mid_reset_y", o_y, 0);
    check("mid_reset_colour", o_c, 0);
    check("mid_reset_busy", o_busy, 0);
    check("mid_reset_ready", o_rdy, 1);
    dn_cnt = 0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (o_done) dn_cnt++; end
    check("mid_reset_no_done", dn_cnt, 0);
    @(negedge clk);
    resetn = 1'b1;
    in_char = 7'd49; in_col = 5'd2; in_row = 3'd1; in_cursor = 1'b0; in_valid = 1'b1;
    check("post_reset_ready", o_rdy, 1);
    @(posedge clk); #1;
    t0 = cyc;
    in_valid = 1'b0;
    check("post_reset_accept", o_busy, 1);
    collect(2, 1, 0);
    check("post_reset_done", done_n, 130);
    check("post_reset_row8", img[8], 8'h7C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
